fence_flush_ctrl: RTL

Sequencer for FENCE and FENCE.I. It sits between the commit stage and the cache subsystem, and serialises each fence through four steps: store-buffer drain, optional data-cache flush (write-back HPDcache), optional instruction-cache invalidate, and a completion pulse to commit and the frontend. It accepts one fence at a time and keeps a per-fence latency measurement for performance monitoring.

---
 rtl/fence_flush_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/fence_flush_ctrl.sv
// Sequences FENCE/FENCE.I: store drain, optional D$ flush, optional I$ invalidate, then a done pulse.
// One fence in flight; fence_ready_o stays low from accept until the cycle after done_o.
module fence_flush_ctrl #(
    parameter bit          DcacheFlushOnFence      = 1'b1,
    parameter bit          DcacheInvalidateOnFlush = 1'b0,
    parameter int unsigned LatWidth                = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                fence_valid_i,
    input  logic                fence_i_i,
    output logic                fence_ready_o,
    input  logic                stores_empty_i,
    output logic                dcache_flush_o,
    output logic                dcache_flush_inval_o,
    input  logic                dcache_flush_ack_i,
    output logic                icache_flush_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                flush_frontend_o,
    output logic [LatWidth-1:0] latency_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DRAIN    = 3'd1,
        S_DC_FLUSH = 3'd2,
        S_IC_INV   = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    localparam logic [LatWidth-1:0] LatMax = {LatWidth{1'b1}};
    localparam logic [LatWidth-1:0] LatOne = LatWidth'(1);

    state_e              state_q, state_d;
    logic                kind_q, kind_d;
    logic [LatWidth-1:0] lat_cnt_q, lat_cnt_d;
    logic [LatWidth-1:0] latency_q, latency_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            kind_q    <= 1'b0;
            lat_cnt_q <= '0;
            latency_q <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            lat_cnt_q <= lat_cnt_d;
            latency_q <= latency_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fence_valid_i) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (stores_empty_i) begin
                    if (DcacheFlushOnFence) state_d = S_DC_FLUSH;
                    else if (kind_q)        state_d = S_IC_INV;
                    else                    state_d = S_DONE;
                end
            end
            S_DC_FLUSH: begin
                if (dcache_flush_ack_i) state_d = kind_q ? S_IC_INV : S_DONE;
            end
            S_IC_INV: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Latency covers every cycle spent working on the fence, saturating rather than wrapping.
    always_comb begin
        kind_d    = kind_q;
        lat_cnt_d = lat_cnt_q;
        latency_d = latency_q;
        case (state_q)
            S_IDLE: begin
                if (fence_valid_i) begin
                    kind_d    = fence_i_i;
                    lat_cnt_d = '0;
                end
            end
            S_DRAIN, S_DC_FLUSH, S_IC_INV: begin
                if (lat_cnt_q != LatMax) lat_cnt_d = lat_cnt_q + LatOne;
            end
            S_DONE:  latency_d = lat_cnt_q;
            default: ;
        endcase
    end

    always_comb begin
        fence_ready_o        = (state_q == S_IDLE);
        busy_o               = (state_q != S_IDLE);
        dcache_flush_o       = (state_q == S_DC_FLUSH);
        dcache_flush_inval_o = (state_q == S_DC_FLUSH) & DcacheInvalidateOnFlush;
        icache_flush_o       = (state_q == S_IC_INV);
        done_o               = (state_q == S_DONE);
        flush_frontend_o     = (state_q == S_DONE) & kind_q;
        latency_o            = latency_q;
    end

endmodule
